// File: rtl/pwm_pkg.sv
// Shared definitions for the servo PWM generator and the PWM capture block.
package pwm_pkg;

    localparam int CLK_HZ       = 10_000_000;
    localparam int SERVO_PERIOD = 199_999;
    localparam int CAP_TIMEOUT  = 400_000;

    typedef enum logic [1:0] {
        SYNC,
        HIGH,
        LOW
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// N-flop synchronizer for an asynchronous input, with rise/fall strobes.
// Edges are suppressed until the flop chain holds real samples, so an input
// that is already high when reset releases does not look like a rising edge.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              q_d;
    logic [STAGES:0]   fill;
    logic              primed;

    // Shift the input through the synchronizer and track when it is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
            q_d   <= 1'b0;
            fill  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            chain <= {chain[STAGES-2:0], d};
            q_d   <= chain[STAGES-1];
            fill  <= {fill[STAGES-1:0], 1'b1};
        end
    end

    assign primed = fill[STAGES];
    assign q      = chain[STAGES-1];
    assign rise   = primed &  q & ~q_d;
    assign fall   = primed & ~q &  q_d;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input in clk cycles,
// with a sticky loss-of-signal flag when no period completes in time.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = 24,
    parameter int TIMEOUT     = CAP_TIMEOUT,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] width,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             lost
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic             in_s;
    logic             rise;
    logic             fall;
    cap_state_t       state_q, state_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             capture;
    logic             timeout;

    sync_edge #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (pwm_in),
        .q    (in_s),
        .rise (rise),
        .fall (fall)
    );

    // State and measurement counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SYNC;
            hi_q    <= '0;
            per_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            per_q   <= per_d;
        end
    end

    // Next state, counter updates and capture/timeout strobes.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        hi_d    = hi_q;
        per_d   = per_q;
        capture = 1'b0;
        timeout = 1'b0;

        if (!en) begin
            state_d = SYNC;
            hi_d    = '0;
            per_d   = '0;
        end else begin
            case (state_q)
                SYNC: begin
                    hi_d  = '0;
                    per_d = '0;
                    if (rise) begin
                        hi_d    = ONE;
                        per_d   = ONE;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    if (per_q == TIMEOUT_C) begin
                        timeout = 1'b1;
                        state_d = SYNC;
                        hi_d    = '0;
                        per_d   = '0;
                    end else begin
                        per_d = per_q + ONE;
                        if (in_s) hi_d = hi_q + ONE;
                        if (fall) state_d = LOW;
                    end
                end
                LOW: begin
                    // Timeout is tested first so it wins over a coincident rise.
                    if (per_q == TIMEOUT_C) begin
                        timeout = 1'b1;
                        state_d = SYNC;
                        hi_d    = '0;
                        per_d   = '0;
                    end else if (rise) begin
                        capture = 1'b1;
                        hi_d    = ONE;
                        per_d   = ONE;
                        state_d = HIGH;
                    end else begin
                        per_d = per_q + ONE;
                    end
                end
                default: begin
                    state_d = SYNC;
                    hi_d    = '0;
                    per_d   = '0;
                end
            endcase
        end
    end

    // Result registers, one-cycle valid strobe and sticky loss flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            width  <= '0;
            period <= '0;
            valid  <= 1'b0;
            lost   <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                width  <= hi_q;
                period <= per_q;
            end
            if (timeout) begin
                lost <= 1'b1;
            end else if (capture) begin
                lost <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a shortened timeout so loss cases fit in a short run.
module tb_pwm_capture;

    localparam int CNT_W = 24;
    localparam int T     = 300;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             lost;

    int checks    = 0;
    int failures  = 0;
    int valid_cnt = 0;

    pwm_capture #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (T),
        .SYNC_STAGES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .pwm_in(pwm_in),
        .width (width),
        .period(period),
        .valid (valid),
        .lost  (lost)
    );

    always #50 clk = ~clk;

    // Count every cycle in which valid is seen high.
    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt <= valid_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int h, input int l);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    // Raise the input and check the capture of the previous period; ends 4 cycles after the rise.
    task automatic rise_chk(input int ew, input int ep);
        pwm_in = 1'b1;
        @(negedge clk);
        check("valid_lat1", valid, 0);
        @(negedge clk);
        check("valid_lat2", valid, 0);
        @(negedge clk);
        check("valid_pulse", valid, 1);
        check("width", width, ew);
        check("period", period, ep);
        check("lost_clear", lost, 0);
        @(negedge clk);
        check("valid_one_cycle", valid, 0);
    endtask

    task automatic pulse_chk(input int h, input int l, input int ew, input int ep);
        rise_chk(ew, ep);
        repeat (h - 4) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        en     = 1'b1;
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_width", width, 0);
        check("rst_period", period, 0);
        check("rst_valid", valid, 0);
        check("rst_lost", lost, 0);

        // Release reset while the input is already high: the partial pulse is discarded.
        reset = 1'b0;
        repeat (50) @(negedge clk);
        pwm_in = 1'b0;
        repeat (100) @(negedge clk);
        check("partial_no_valid", valid_cnt, 0);
        pulse(40, 160);
        check("first_period_no_valid", valid_cnt, 0);
        pulse_chk(25, 75, 40, 200);
        pulse(1, 9);
        pulse_chk(40, 160, 1, 10);
        check("valid_count_a", valid_cnt, 3);

        // Stuck low: lost rises exactly T cycles after the capture edge of the last rise.
        repeat (102) @(negedge clk);
        check("stuck_low_before", lost, 0);
        @(negedge clk);
        check("stuck_low_lost", lost, 1);
        check("stuck_low_width_hold", width, 1);
        check("stuck_low_period_hold", period, 10);
        check("stuck_low_no_valid", valid_cnt, 3);

        // Restore: one rise re-arms, the next captures and clears lost.
        pulse(30, 70);
        check("restore_lost_held", lost, 1);
        check("restore_no_valid", valid_cnt, 3);
        pulse_chk(30, 70, 30, 100);

        // Stuck high.
        rise_chk(30, 100);
        repeat (T - 2) @(negedge clk);
        check("stuck_high_before", lost, 0);
        @(negedge clk);
        check("stuck_high_lost", lost, 1);
        check("stuck_high_width_hold", width, 30);
        check("valid_count_b", valid_cnt, 5);
        pwm_in = 1'b0;
        repeat (20) @(negedge clk);

        // Enable dropped mid-period, spanning a rise, re-enabled while the input is high.
        pulse(50, 150);
        rise_chk(50, 200);
        repeat (19) @(negedge clk);
        en = 1'b0;
        repeat (27) @(negedge clk);
        pwm_in = 1'b0;
        repeat (150) @(negedge clk);
        pwm_in = 1'b1;
        repeat (23) @(negedge clk);
        en = 1'b1;
        check("en_width_hold", width, 50);
        check("en_period_hold", period, 200);
        check("en_lost_hold", lost, 0);
        check("en_no_valid", valid_cnt, 6);
        repeat (27) @(negedge clk);
        pwm_in = 1'b0;
        repeat (150) @(negedge clk);
        pulse(50, 150);
        check("en_first_rise_no_valid", valid_cnt, 6);
        pulse_chk(100, 199, 50, 200);

        // Longest measurable period is T-1; a rise at exactly T loses to the timeout.
        pulse_chk(100, 200, 100, 299);
        pwm_in = 1'b1;
        repeat (3) @(negedge clk);
        check("tmo_vs_rise_valid", valid, 0);
        check("tmo_vs_rise_lost", lost, 1);
        check("tmo_vs_rise_width", width, 100);
        check("tmo_vs_rise_period", period, 299);
        check("valid_count_c", valid_cnt, 8);

        // Asynchronous reset in the middle of a high pulse.
        pwm_in = 1'b0;
        repeat (50) @(negedge clk);
        pwm_in = 1'b1;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_width", width, 0);
        check("midrst_period", period, 0);
        check("midrst_valid", valid, 0);
        check("midrst_lost", lost, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        pwm_in = 1'b0;
        repeat (100) @(negedge clk);
        pulse(40, 160);
        check("midrst_no_valid", valid_cnt, 8);
        pulse_chk(40, 160, 40, 200);
        check("valid_count_d", valid_cnt, 9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
